// File: rtl/clock_gating_controller.sv
// Per-domain wake/idle sequencer driving clock_gating_cell enables; all outputs registered, one edge after input sampling.
// No backpressure: busy/force_on/disable_mask are levels; disable_mask has priority over all requests.
module clock_gating_controller #(
    parameter int NUM_DOMAINS = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_DOMAINS-1:0]   busy,
    input  logic                     force_on,
    input  logic [NUM_DOMAINS-1:0]   disable_mask,
    output logic [NUM_DOMAINS-1:0]   clk_enable,
    output logic [NUM_DOMAINS-1:0]   ready,
    output logic [2*NUM_DOMAINS-1:0] state_out
);

    localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES);
    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t                   state_q [NUM_DOMAINS];
    state_t                   state_d [NUM_DOMAINS];
    logic [CW-1:0]            cnt_q   [NUM_DOMAINS];
    logic [CW-1:0]            cnt_d   [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0]   req;
    logic [NUM_DOMAINS-1:0]   clk_enable_q, clk_enable_d;
    logic [NUM_DOMAINS-1:0]   ready_q, ready_d;
    logic [2*NUM_DOMAINS-1:0] state_out_q, state_out_d;

    always_comb begin
        req          = (busy | {NUM_DOMAINS{force_on}}) & ~disable_mask;
        clk_enable_d = '0;
        ready_d      = '0;
        state_out_d  = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (disable_mask[i]) begin
                state_d[i] = ST_OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_OFF: begin
                        if (req[i]) begin
                            state_d[i] = ST_WAKE;
                            cnt_d[i]   = WAKE_LOAD;
                        end
                    end
                    // Wake always runs to completion, even if the request goes away.
                    ST_WAKE: begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                        if (cnt_q[i] <= CNT_ONE) begin
                            state_d[i] = ST_ON;
                            cnt_d[i]   = '0;
                        end
                    end
                    ST_ON: begin
                        if (!req[i]) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = IDLE_LOAD;
                        end
                    end
                    // A returning request beats an expiring counter on the same edge.
                    ST_IDLE: begin
                        if (req[i]) begin
                            state_d[i] = ST_ON;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] <= CNT_ONE) begin
                            state_d[i] = ST_OFF;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            clk_enable_d[i]       = (state_d[i] != ST_OFF);
            ready_d[i]            = (state_d[i] == ST_ON) || (state_d[i] == ST_IDLE);
            state_out_d[2*i +: 2] = state_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
            clk_enable_q <= '0;
            ready_q      <= '0;
            state_out_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clk_enable_q <= clk_enable_d;
            ready_q      <= ready_d;
            state_out_q  <= state_out_d;
        end
    end

    assign clk_enable = clk_enable_q;
    assign ready      = ready_q;
    assign state_out  = state_out_q;

endmodule

// File: tb/tb_clock_gating_controller.sv
// Directed + random bench for clock_gating_controller against a timestamp-based reference model.
`timescale 1ps/1ps
module tb_clock_gating_controller;

    localparam int N    = 4;
    localparam int IDLE = 8;
    localparam int WAKE = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   busy = '0;
    logic           force_on = 1'b0;
    logic [N-1:0]   disable_mask = '0;
    logic [N-1:0]   clk_enable;
    logic [N-1:0]   ready;
    logic [2*N-1:0] state_out;

    int total = 0;
    int bad   = 0;

    // Reference model: a domain is "active" from the edge it was woken; it is
    // ready once WAKE edges have passed since then, and it turns off after
    // IDLE+1 consecutive low request samples observed while ready.
    bit m_active [N];
    int m_wake_t [N];
    int m_idle   [N];
    int t = 0;

    logic [N-1:0]   exp_en, exp_rdy;
    logic [2*N-1:0] exp_st;

    clock_gating_controller #(
        .NUM_DOMAINS(N), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)
    ) dut (
        .clk(clk), .rst(rst), .busy(busy), .force_on(force_on),
        .disable_mask(disable_mask), .clk_enable(clk_enable),
        .ready(ready), .state_out(state_out)
    );

    always #10 clk = ~clk;

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit r;
            r = (busy[i] | force_on) & ~disable_mask[i];
            if (rst || disable_mask[i]) begin
                m_active[i] = 1'b0;
                m_idle[i]   = 0;
            end else if (!m_active[i]) begin
                if (r) begin
                    m_active[i] = 1'b1;
                    m_wake_t[i] = t;
                    m_idle[i]   = 0;
                end
            end else if (t - m_wake_t[i] > WAKE) begin
                if (r) m_idle[i] = 0;
                else begin
                    m_idle[i]++;
                    if (m_idle[i] > IDLE) begin
                        m_active[i] = 1'b0;
                        m_idle[i]   = 0;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            exp_en[i]  = m_active[i];
            exp_rdy[i] = m_active[i] && (t - m_wake_t[i] >= WAKE);
            if (!m_active[i])                  exp_st[2*i +: 2] = 2'd0;
            else if (t - m_wake_t[i] < WAKE)   exp_st[2*i +: 2] = 2'd1;
            else if (m_idle[i] > 0)            exp_st[2*i +: 2] = 2'd3;
            else                               exp_st[2*i +: 2] = 2'd2;
        end
    endtask

    task automatic step(input logic [N-1:0] b, input logic f, input logic [N-1:0] m,
                        input logic r, input string tag);
        busy = b; force_on = f; disable_mask = m; rst = r;
        @(posedge clk);
        t++;
        model_edge();
        #1;
        total++;
        assert (clk_enable === exp_en) else begin
            bad++;
            $error("FAIL %s clk_enable t=%0d got=%h exp=%h", tag, t, clk_enable, exp_en);
        end
        total++;
        assert (ready === exp_rdy) else begin
            bad++;
            $error("FAIL %s ready t=%0d got=%h exp=%h", tag, t, ready, exp_rdy);
        end
        total++;
        assert (state_out === exp_st) else begin
            bad++;
            $error("FAIL %s state_out t=%0d got=%h exp=%h", tag, t, state_out, exp_st);
        end
    endtask

    initial begin
        logic [N-1:0] rb;
        logic         rf;
        logic [N-1:0] rm;
        logic         rr;

        // Reset held with every domain busy
        repeat (3) step(4'hF, 1'b0, 4'h0, 1'b1, "reset");
        total++;
        assert (state_out === 8'h00) else begin
            bad++;
            $error("FAIL reset_state got=%h exp=%h", state_out, 8'h00);
        end

        // Release with busy high: enable after 1 edge, ready after 3
        step(4'hF, 1'b0, 4'h0, 1'b0, "release");
        total++;
        assert (clk_enable === 4'hF && ready === 4'h0) else begin
            bad++;
            $error("FAIL release_e1 got=%h/%h exp=f/0", clk_enable, ready);
        end
        repeat (2) step(4'hF, 1'b0, 4'h0, 1'b0, "release");
        total++;
        assert (ready === 4'hF && state_out === 8'hAA) else begin
            bad++;
            $error("FAIL release_e3 got=%h/%h exp=f/aa", ready, state_out);
        end
        repeat (12) step(4'h0, 1'b0, 4'h0, 1'b0, "drain");

        // Domain 0 busy pulse of 5 cycles
        repeat (5)  step(4'h1, 1'b0, 4'h0, 1'b0, "pulse0");
        repeat (15) step(4'h0, 1'b0, 4'h0, 1'b0, "pulse0_idle");

        // Domain 1 idle rescue: 7 low cycles, then low up to the expiry edge
        repeat (5) step(4'h2, 1'b0, 4'h0, 1'b0, "rescue_on");
        repeat (7) step(4'h0, 1'b0, 4'h0, 1'b0, "rescue_low7");
        repeat (3) step(4'h2, 1'b0, 4'h0, 1'b0, "rescue_back");
        repeat (8) step(4'h0, 1'b0, 4'h0, 1'b0, "rescue_low8");
        step(4'h2, 1'b0, 4'h0, 1'b0, "rescue_expiry");
        total++;
        assert (state_out[3:2] === 2'd2 && clk_enable[1] === 1'b1) else begin
            bad++;
            $error("FAIL rescue_expiry_on got=%0d/%b exp=2/1", state_out[3:2], clk_enable[1]);
        end
        repeat (12) step(4'h0, 1'b0, 4'h0, 1'b0, "rescue_drain");

        // Disable beats busy and force_on, then rewake after mask clears
        repeat (4) step(4'h4, 1'b0, 4'h0, 1'b0, "dis_on");
        step(4'h4, 1'b1, 4'h4, 1'b0, "dis_hit");
        total++;
        assert (state_out[5:4] === 2'd0 && clk_enable[2] === 1'b0 && ready[2] === 1'b0) else begin
            bad++;
            $error("FAIL dis_hit got=%0d/%b/%b exp=0/0/0", state_out[5:4], clk_enable[2], ready[2]);
        end
        step(4'h4, 1'b0, 4'h0, 1'b0, "dis_clear");
        repeat (3)  step(4'h4, 1'b0, 4'h0, 1'b0, "dis_rewake");
        repeat (12) step(4'h0, 1'b0, 4'h0, 1'b0, "dis_drain");

        // Global force_on with no busy
        repeat (4)  step(4'h0, 1'b1, 4'h0, 1'b0, "force");
        repeat (12) step(4'h0, 1'b0, 4'h0, 1'b0, "force_drop");

        // Reset in the middle of WAKE and of IDLE
        step(4'hF, 1'b0, 4'h0, 1'b0, "rst_wake_pre");
        step(4'hF, 1'b0, 4'h0, 1'b1, "rst_wake");
        repeat (4) step(4'hF, 1'b0, 4'h0, 1'b0, "rst_wake_post");
        repeat (3) step(4'h0, 1'b0, 4'h0, 1'b0, "rst_idle_pre");
        step(4'hF, 1'b0, 4'h0, 1'b1, "rst_idle");
        repeat (4)  step(4'hF, 1'b0, 4'h0, 1'b0, "rst_idle_post");
        repeat (12) step(4'h0, 1'b0, 4'h0, 1'b0, "rst_drain");

        // Random traffic with sticky levels so hysteresis windows get exercised
        rb = '0; rf = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
            if ($urandom_range(0, 39) == 0) rf = ~rf;
            rm = '0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 49) == 0) rm[i] = 1'b1;
            rr = ($urandom_range(0, 299) == 0);
            step(rb, rf, rm, rr, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
